// File: rtl/conv2d_stream_kxk.sv
// Streaming KxK 2D convolution over a raster image with internal zero padding,
// valid/ready on both sides, frame delimiting via i_last and optional |sum| output.
module conv2d_stream_kxk #(
    parameter int IMG_W  = 512,
    parameter int K      = 3,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = PIX_W + COEF_W + $clog2(K * K)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [K*K*COEF_W-1:0]   i_f,
    input  logic                    i_abs,
    input  logic                    i_valid,
    input  logic [PIX_W-1:0]        i_x,
    input  logic                    i_last,
    output logic                    o_ready,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [PIX_W-1:0]        o_y,
    output logic                    o_last
);

    localparam int P  = (K - 1) / 2;
    localparam int CW = $clog2(IMG_W + P + 1);
    localparam int AW = $clog2(IMG_W);
    localparam int RW = $clog2(K);
    localparam int BW = $clog2(P + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_END  = CW'(IMG_W + P - 1);
    localparam logic [CW-1:0] COL_IMG  = CW'(IMG_W);
    localparam logic [CW-1:0] COL_P    = CW'(P);
    localparam logic [RW-1:0] ROW_MAX  = RW'(K - 1);
    localparam logic [RW-1:0] ROW_P    = RW'(P);
    localparam logic [BW-1:0] BROW_P   = BW'(P);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_RPAD, S_BPAD, S_DRAIN} state_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [BW-1:0]            r_bRow;
    logic                     r_lastPend;
    logic [K*K*COEF_W-1:0]    r_f;
    logic                     r_abs;
    logic [PIX_W-1:0]         r_lb [K-1][IMG_W];
    logic [PIX_W-1:0]         r_win [K][K];
    logic                     r_s1Valid;
    logic                     r_s1Last;
    logic                     r_oValid;
    logic                     r_oLast;
    logic [PIX_W-1:0]         r_oY;

    logic                     w_adv;
    logic                     w_ready;
    logic                     w_slot;
    logic [PIX_W-1:0]         w_pixIn;
    logic                     w_produce;
    logic                     w_isLast;
    logic [AW-1:0]            w_addr;
    logic [PIX_W-1:0]         w_colVec [K];
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_mag;
    logic [PIX_W-1:0]         w_clamp;

    // Everything internal moves only when the output register is empty or draining.
    assign w_adv     = ~r_oValid | i_ready;
    assign w_produce = (r_row >= ROW_P) && (r_col >= COL_P);
    assign w_isLast  = (r_state == S_BPAD) && (r_bRow == BROW_P) && (r_col == COL_END);
    assign w_addr    = r_col[AW-1:0];
    assign o_ready   = w_ready & ~reset;
    assign o_valid   = r_oValid;
    assign o_last    = r_oLast;
    assign o_y       = r_oY;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_slot      = 1'b0;
        w_pixIn     = '0;
        case (r_state)
            S_IDLE, S_RUN: begin
                w_ready = w_adv;
                w_slot  = i_valid & w_adv;
                w_pixIn = i_x;
                if (w_slot) begin
                    if (r_col == COL_LAST) w_nextState = (i_last | r_lastPend) ? S_BPAD : S_RPAD;
                    else                   w_nextState = S_RUN;
                end
            end
            S_RPAD: begin
                w_slot = w_adv;
                if (w_slot && r_col == COL_END) w_nextState = S_RUN;
            end
            S_BPAD: begin
                w_slot = w_adv;
                if (w_slot && r_col == COL_END && r_bRow == BROW_P) w_nextState = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_oValid && r_oLast && i_ready) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Slot position tracking; the row count saturates since only rows < K-1 need masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_bRow     <= '0;
            r_lastPend <= 1'b0;
            r_f        <= '0;
            r_abs      <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            r_col      <= '0;
            r_row      <= '0;
            r_bRow     <= '0;
            r_lastPend <= 1'b0;
        end else if (w_slot) begin
            if (r_state == S_IDLE) begin
                r_f   <= i_f;
                r_abs <= i_abs;
            end
            if ((r_state == S_IDLE || r_state == S_RUN) && i_last && r_col != COL_LAST)
                r_lastPend <= 1'b1;
            if (r_col == COL_END) begin
                r_col <= '0;
                if (r_row != ROW_MAX) r_row <= r_row + 1'b1;
                if (r_state == S_BPAD && r_bRow != BROW_P) r_bRow <= r_bRow + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // New window column: padded columns are all zero, rows above the image are masked.
    always_comb begin
        for (int rr = 0; rr < K; rr++) w_colVec[rr] = '0;
        if (r_col < COL_IMG) begin
            w_colVec[K-1] = w_pixIn;
            for (int j = 0; j < K - 1; j++)
                if (RW'(j) < r_row) w_colVec[K-2-j] = r_lb[j][w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_slot && r_col < COL_IMG) begin
            r_lb[0][w_addr] <= w_pixIn;
            for (int j = 1; j < K - 1; j++) r_lb[j][w_addr] <= r_lb[j-1][w_addr];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int rr = 0; rr < K; rr++)
            for (int cc = 0; cc < K; cc++)
                w_sum = w_sum + ACC_W'($signed(r_f[(rr*K+cc)*COEF_W +: COEF_W]))
                              * ACC_W'($signed({1'b0, r_win[rr][cc]}));
        w_mag = (r_abs && w_sum[ACC_W-1]) ? -w_sum : w_sum;
        if (w_mag[ACC_W-1])               w_clamp = '0;
        else if (|w_mag[ACC_W-2:PIX_W])   w_clamp = '1;
        else                              w_clamp = w_mag[PIX_W-1:0];
    end

    // Two-stage pipeline: window register, then the saturated output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1Last  <= 1'b0;
            r_oValid  <= 1'b0;
            r_oLast   <= 1'b0;
            r_oY      <= '0;
            for (int rr = 0; rr < K; rr++)
                for (int cc = 0; cc < K; cc++) r_win[rr][cc] <= '0;
        end else if (w_adv) begin
            r_s1Valid <= w_slot & w_produce;
            r_s1Last  <= w_slot & w_isLast;
            r_oValid  <= r_s1Valid;
            r_oLast   <= r_s1Last;
            r_oY      <= w_clamp;
            if (w_slot) begin
                for (int rr = 0; rr < K; rr++) begin
                    for (int cc = 0; cc < K - 1; cc++)
                        r_win[rr][cc] <= (r_col == '0) ? '0 : r_win[rr][cc+1];
                    r_win[rr][K-1] <= w_colVec[rr];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_kxk.sv
// Self-checking bench for conv2d_stream_kxk: a K=3/8-wide and a K=5/16-wide instance
// driven with directed and random frames, compared against a plain-arithmetic convolution model.
module tb_conv2d_stream_kxk;

    logic         clk = 1'b0;
    logic         reset;
    logic [199:0] coefBus;
    logic         iAbs, iValid, iLast, iReady;
    logic [7:0]   iX;
    logic         sel;
    logic         o3Ready, o3Valid, o3Last, o5Ready, o5Valid, o5Last;
    logic [7:0]   o3Y, o5Y;
    logic         oReady, oValid, oLast;
    logic [7:0]   oY;

    int           img [8][16];
    int           f [5][5];
    bit           absMode;
    int           expY[$];
    bit           expLast[$];
    int           nChecks = 0;
    int           nPass = 0;
    int           nFail = 0;

    always #5 clk = ~clk;

    conv2d_stream_kxk #(.IMG_W(8), .K(3), .PIX_W(8), .COEF_W(8)) dut3 (
        .clk(clk), .reset(reset), .i_f(coefBus[71:0]), .i_abs(iAbs),
        .i_valid(iValid & ~sel), .i_x(iX), .i_last(iLast), .o_ready(o3Ready),
        .o_valid(o3Valid), .i_ready(iReady | sel), .o_y(o3Y), .o_last(o3Last));

    conv2d_stream_kxk #(.IMG_W(16), .K(5), .PIX_W(8), .COEF_W(8)) dut5 (
        .clk(clk), .reset(reset), .i_f(coefBus), .i_abs(iAbs),
        .i_valid(iValid & sel), .i_x(iX), .i_last(iLast), .o_ready(o5Ready),
        .o_valid(o5Valid), .i_ready(iReady | ~sel), .o_y(o5Y), .o_last(o5Last));

    assign oReady = sel ? o5Ready : o3Ready;
    assign oValid = sel ? o5Valid : o3Valid;
    assign oLast  = sel ? o5Last  : o3Last;
    assign oY     = sel ? o5Y     : o3Y;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Zero-padded convolution, then optional abs, then clamp to 0..255.
    task automatic buildModel(input int w, input int h, input int k);
        int p, sum, rr, cc;
        p = (k - 1) / 2;
        expY.delete();
        expLast.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                sum = 0;
                for (int dr = 0; dr < k; dr++)
                    for (int dc = 0; dc < k; dc++) begin
                        rr = r - p + dr;
                        cc = c - p + dc;
                        if (rr >= 0 && rr < h && cc >= 0 && cc < w) sum += f[dr][dc] * img[rr][cc];
                    end
                if (absMode && sum < 0) sum = -sum;
                if (sum < 0) sum = 0;
                if (sum > 255) sum = 255;
                expY.push_back(sum);
                expLast.push_back(r == h - 1 && c == w - 1);
            end
    endtask

    task automatic loadCoefs(input int k);
        coefBus = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) coefBus[(r*k+c)*8 +: 8] = 8'(f[r][c]);
        iAbs = absMode;
    endtask

    task automatic randomImage(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) img[r][c] = int'($urandom_range(255));
    endtask

    task automatic randomCoefs(input int k);
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) f[r][c] = int'($urandom_range(255)) - 128;
        absMode = 1'($urandom_range(1));
    endtask

    // One full frame: random valid/ready duty, optional coef scrambling after capture.
    task automatic applyStimulus(input int w, input int h, input int k, input int vPct,
                                 input int rPct, input bit scramble);
        int n, idx, got, cyc, budget;
        logic [7:0] heldY;
        logic heldLast;
        bit held;
        buildModel(w, h, k);
        loadCoefs(k);
        n = w * h;
        idx = 0; got = 0; cyc = 0; held = 0;
        budget = 40 * (h + 3) * (w + 3) + 200;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            if (scramble && idx > 0) begin
                for (int i = 0; i < 25; i++) coefBus[i*8 +: 8] = 8'($urandom);
                iAbs = 1'($urandom_range(1));
            end
            if (idx < n && $urandom_range(99) < vPct) begin
                iValid = 1'b1;
                iX = 8'(img[idx / w][idx % w]);
                iLast = (idx == n - 1);
            end else begin
                iValid = 1'b0;
                iX = 8'($urandom);
                iLast = 1'b0;
            end
            iReady = ($urandom_range(99) < rPct);
            #1;
            if (held) begin
                checkOutput("hold", {oValid, oLast, oY}, {1'b1, heldLast, heldY});
                held = 0;
            end
            if (idx == n) checkOutput("ready_low_tail", oReady, 0);
            if (iValid && oReady) idx++;
            if (oValid) begin
                if (iReady) begin
                    checkOutput("y", oY, expY[got]);
                    checkOutput("last", oLast, expLast[got]);
                    got++;
                end else begin
                    held = 1; heldY = oY; heldLast = oLast;
                end
            end
            cyc++;
        end
        checkOutput("frame_count", got, n);
        iValid = 1'b0; iLast = 1'b0; iReady = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("idle_valid", oValid, 0);
        checkOutput("idle_ready", oReady, 1);
    endtask

    initial begin
        reset = 1'b1; iValid = 1'b0; iLast = 1'b0; iReady = 1'b1; iX = '0;
        iAbs = 1'b0; coefBus = '0; sel = 1'b0; absMode = 0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_ready3", o3Ready, 0);
        checkOutput("rst_ready5", o5Ready, 0);
        checkOutput("rst_valid", o3Valid, 0);
        checkOutput("rst_last", o3Last, 0);
        checkOutput("rst_y", o3Y, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ready", o3Ready, 1);

        // Identity kernel on a ramp.
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) f[r][c] = 0;
        f[1][1] = 1;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = r * 8 + c;
        applyStimulus(8, 4, 3, 100, 100, 0);

        // Saturation: all-ones kernel on white, then all -1.
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = 255;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) f[r][c] = 1;
        applyStimulus(8, 4, 3, 100, 100, 1);
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) f[r][c] = -1;
        applyStimulus(8, 4, 3, 100, 100, 1);

        // Laplacian impulse, signed then abs.
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) f[r][c] = -1;
        f[1][1] = 8;
        for (int r = 0; r < 5; r++) for (int c = 0; c < 8; c++) img[r][c] = 0;
        img[2][2] = 100;
        absMode = 0;
        applyStimulus(8, 5, 3, 100, 100, 0);
        absMode = 1;
        applyStimulus(8, 5, 3, 100, 80, 0);

        // Back-to-back random K=3 frames with differing coefficients.
        for (int t = 0; t < 2; t++) begin
            randomCoefs(3);
            randomImage(8, 6);
            applyStimulus(8, 6, 3, 70, 70, 1);
        end

        // K=5 random frames under 50% valid/ready toggling.
        sel = 1'b1;
        for (int t = 0; t < 2; t++) begin
            randomCoefs(5);
            randomImage(16, 6);
            applyStimulus(16, 6, 5, 50, 50, 1);
        end

        // Reset in the middle of a frame, then a clean frame.
        randomCoefs(5);
        loadCoefs(5);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            iValid = 1'b1; iX = 8'($urandom); iLast = 1'b0; iReady = 1'b1;
        end
        @(negedge clk);
        iValid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midrst_ready", oReady, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", oValid, 0);
        checkOutput("midrst_last", oLast, 0);
        checkOutput("midrst_ready_after", oReady, 1);
        randomCoefs(5);
        randomImage(16, 5);
        applyStimulus(16, 5, 5, 60, 60, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
